axi_rd_arbiter: RTL and testbench
=================================

Name: axi_rd_arbiter

Overview:
- Arbitrates the single AXI read-address channel between the instruction-fetch and data-load SRAM-like request ports of the CPU bridge.
- Registers the granted request and holds arvalid until arready.
- Tracks outstanding reads per AXI ID so in-flight reads never exceed the limit.
- Blocks data reads that hit a pending write (read-after-write hazard).

Parameters:
- MAX_OUTST, 2, maximum outstanding reads per ID (1..7).
- ADDR_W, 32, address width.

Ports:
- clk  in  1  clock, rising edge
- resetn  in  1  asynchronous active-low reset
- inst_req  in  1  instruction read request
- inst_addr  in  ADDR_W  instruction read address
- inst_size  in  2  log2 bytes
- inst_addr_ok  out  1  instruction request accepted this cycle
- data_req  in  1  data read request
- data_addr  in  ADDR_W  data read address
- data_size  in  2  log2 bytes
- data_addr_ok  out  1  data request accepted this cycle
- wr_busy  in  1  write in flight (AW/W issued, B not yet received)
- wr_addr  in  ADDR_W  address of the in-flight write
- arid  out  4  0 = inst, 1 = data
- araddr  out  ADDR_W  read address
- arlen  out  8  constant 0
- arsize  out  3  {1'b0, size}
- arburst  out  2  constant 2'b01
- arlock  out  2  constant 0
- arcache  out  4  constant 0
- arprot  out  3  constant 0
- arvalid  out  1  AR valid
- arready  in  1  AR ready
- rid  in  4  R channel ID
- rvalid  in  1  R valid
- rready  in  1  R ready (observed only, driven elsewhere)
- rlast  in  1  R last beat

Behaviour:
- Reset (asynchronous, resetn=0): state=IDLE, arvalid=0, arid/araddr/arsize=0, both outstanding counters=0, rr pointer=inst; addr_ok outputs are 0 while resetn=0.
- States are IDLE and ISSUE.
- Eligibility:
  - inst_ok = inst_req && cnt_inst<MAX_OUTST.
  - data_ok = data_req && cnt_data<MAX_OUTST && !(wr_busy && data_addr[ADDR_W-1:2]==wr_addr[ADDR_W-1:2]).
- Grant, IDLE only: data wins when both are eligible (default); the selected port's addr_ok is driven combinationally high in that same cycle. At most one addr_ok is high per cycle.
- On grant: register id/addr/size and go to ISSUE. arvalid=1 from the next cycle (one-cycle request-to-arvalid latency).
- ISSUE:
  - arvalid held, with araddr/arid/arsize stable, until arready.
  - On arvalid&&arready: go to IDLE; both addr_ok outputs stay 0 throughout ISSUE.
  - No back-to-back grant in the handshake cycle; the next grant is possible in the following IDLE cycle.
- Counters:
  - cnt[arid] increments on AR handshake.
  - cnt[rid[0]] decrements on rvalid&&rready&&rlast.
  - Increment and decrement on the same ID in the same cycle leaves the count unchanged.
  - Decrement at 0 is ignored (saturate). Increment is never attempted at MAX_OUTST because eligibility prevents it.
- Hazard compares word addresses only. Instruction reads are never hazard-blocked. A blocked data request with inst_req eligible grants inst.
- Reset asserted mid-ISSUE: arvalid drops immediately, the captured request is discarded, and counters clear.

Optional Feature:
- RR_ARB_EN defined: round-robin between inst and data when both are eligible. A 1-bit pointer flips to the other port after each grant; reset pointer favours inst.
- RR_ARB_EN undefined: fixed data-over-inst priority, no pointer register.

Test Plan:
- Reset, then inst_req=1, addr=0x1C000000, size=2 -> inst_addr_ok=1 same cycle; next cycle arvalid=1, arid=0, araddr=0x1C000000, arsize=3'b010; arready=1 -> IDLE.
- inst_req and data_req both 1, data_addr=0x00001000 -> data_addr_ok=1, arid=1 first. With RR_ARB_EN, the second simultaneous pair grants inst.
- arready held 0 for 5 cycles -> arvalid, araddr, arid stable; both addr_ok outputs 0; new req ignored until handshake.
- MAX_OUTST=2: two data ARs with no R -> third data_req gets no addr_ok. R beat rid=1, rlast=1 -> data_addr_ok returns the next cycle.
- wr_busy=1, wr_addr=0x2004, data_addr=0x2006 -> no data_addr_ok. Change data_addr to 0x2008 -> granted. wr_busy=0 -> 0x2006 granted.
- Assert resetn=0 during ISSUE with cnt_inst=1 -> arvalid=0 immediately, counters 0; after release the new request issues normally.

Source files
------------

// File: rtl/axi_rd_arbiter.sv
// axi_rd_arbiter: shares one AXI AR channel between inst/data read ports, with per-ID outstanding limits and RAW hazard blocking.
// Define RR_ARB_EN for round-robin arbitration; otherwise data has fixed priority over inst.
module axi_rd_arbiter #(
  parameter int MAX_OUTST = 2,
  parameter int ADDR_W    = 32
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              inst_req,
  input  logic [ADDR_W-1:0] inst_addr,
  input  logic [1:0]        inst_size,
  output logic              inst_addr_ok,
  input  logic              data_req,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [1:0]        data_size,
  output logic              data_addr_ok,
  input  logic              wr_busy,
  input  logic [ADDR_W-1:0] wr_addr,
  output logic [3:0]        arid,
  output logic [ADDR_W-1:0] araddr,
  output logic [7:0]        arlen,
  output logic [2:0]        arsize,
  output logic [1:0]        arburst,
  output logic [1:0]        arlock,
  output logic [3:0]        arcache,
  output logic [2:0]        arprot,
  output logic              arvalid,
  input  logic              arready,
  input  logic [3:0]        rid,
  input  logic              rvalid,
  input  logic              rready,
  input  logic              rlast
);
  typedef enum logic {IDLE, ISSUE} state_t;
  state_t            r_state, w_next;
  logic              r_id;
  logic [ADDR_W-1:0] r_addr;
  logic [1:0]        r_size;
  logic [2:0]        r_cnt [2];
  logic              w_inst_ok, w_data_ok, w_pick_data, w_grant, w_hs, w_rdone, w_unused;
  logic [1:0]        w_inc, w_dec;
  assign w_unused  = ^rid[3:1];
  assign w_inst_ok = inst_req && r_cnt[0] < 3'(MAX_OUTST);
  assign w_data_ok = data_req && r_cnt[1] < 3'(MAX_OUTST)
                     && !(wr_busy && data_addr[ADDR_W-1:2] == wr_addr[ADDR_W-1:2]);
`ifdef RR_ARB_EN
  logic r_rr;
  assign w_pick_data = w_data_ok && (!w_inst_ok || r_rr);
  // Pointer favours the port that was not just granted.
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) r_rr <= 1'b0;
    else if (w_grant) r_rr <= !w_pick_data;
`else
  assign w_pick_data = w_data_ok;
`endif
  assign w_grant      = resetn && r_state == IDLE && (w_inst_ok || w_data_ok);
  assign inst_addr_ok = w_grant && !w_pick_data;
  assign data_addr_ok = w_grant && w_pick_data;
  assign w_hs         = arvalid && arready;
  assign w_rdone      = rvalid && rready && rlast;
  assign w_inc        = {w_hs && r_id, w_hs && !r_id};
  assign w_dec        = {w_rdone && rid[0] && r_cnt[1] != 3'd0, w_rdone && !rid[0] && r_cnt[0] != 3'd0};
  always_comb w_next = r_state == IDLE ? (w_grant ? ISSUE : IDLE) : (arready ? IDLE : ISSUE);
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      r_state  <= IDLE;
      r_id     <= 1'b0;
      r_addr   <= '0;
      r_size   <= 2'd0;
      r_cnt[0] <= 3'd0;
      r_cnt[1] <= 3'd0;
    end else begin
      r_state <= w_next;
      if (w_grant) begin
        r_id   <= w_pick_data;
        r_addr <= w_pick_data ? data_addr : inst_addr;
        r_size <= w_pick_data ? data_size : inst_size;
      end
      for (int k = 0; k < 2; k++) r_cnt[k] <= r_cnt[k] + {2'b0, w_inc[k]} - {2'b0, w_dec[k]};
    end
  assign arvalid = r_state == ISSUE;
  assign arid    = {3'b0, r_id};
  assign araddr  = r_addr;
  assign arsize  = {1'b0, r_size};
  assign arlen   = 8'd0;
  assign arburst = 2'b01;
  assign arlock  = 2'b00;
  assign arcache = 4'd0;
  assign arprot  = 3'd0;
endmodule

// File: tb/tb_axi_rd_arbiter.sv
// tb_axi_rd_arbiter: directed vector table plus a mid-ISSUE reset sequence for axi_rd_arbiter (default fixed-priority build).
module tb_axi_rd_arbiter;
  localparam logic [31:0] IA = 32'h1C000000;
  logic        clk = 1'b0, resetn;
  logic        inst_req, data_req, wr_busy, arready, rvalid, rready, rlast;
  logic [31:0] inst_addr, data_addr, wr_addr, araddr;
  logic [1:0]  inst_size, data_size, arburst, arlock;
  logic [3:0]  rid, arid, arcache;
  logic [7:0]  arlen;
  logic [2:0]  arsize, arprot;
  logic        inst_addr_ok, data_addr_ok, arvalid;
  int          n_chk = 0, n_err = 0;

  axi_rd_arbiter dut (
    .clk(clk), .resetn(resetn),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_size(inst_size), .inst_addr_ok(inst_addr_ok),
    .data_req(data_req), .data_addr(data_addr), .data_size(data_size), .data_addr_ok(data_addr_ok),
    .wr_busy(wr_busy), .wr_addr(wr_addr),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rvalid(rvalid), .rready(rready), .rlast(rlast)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic ir, dr; logic [31:0] da; logic wb; logic [31:0] wa;
    logic ardy, rv; logic [3:0] rd; logic rl;
    logic iok, dok, av; logic [3:0] id; logic [31:0] addr; logic [2:0] sz;
  } vec_t;
  vec_t tbl[$];

  task automatic add(input logic ir, dr, input logic [31:0] da, input logic wb, input logic [31:0] wa,
                     input logic ardy, rv, input logic [3:0] rd, input logic rl,
                     input logic iok, dok, av, input logic [3:0] id, input logic [31:0] addr, input logic [2:0] sz);
    vec_t v;
    v.ir = ir; v.dr = dr; v.da = da; v.wb = wb; v.wa = wa; v.ardy = ardy; v.rv = rv; v.rd = rd; v.rl = rl;
    v.iok = iok; v.dok = dok; v.av = av; v.id = id; v.addr = addr; v.sz = sz;
    tbl.push_back(v);
  endtask

  task automatic drive(input logic ir, dr, input logic [31:0] da, input logic wb, input logic [31:0] wa,
                       input logic ardy, rv, input logic [3:0] rd, input logic rl);
    inst_req = ir; data_req = dr; data_addr = da; wr_busy = wb; wr_addr = wa;
    arready = ardy; rvalid = rv; rready = rv; rid = rd; rlast = rl;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  initial begin
    inst_addr = IA; inst_size = 2'd2; data_size = 2'd1;
    resetn = 1'b0;
    drive(1, 1, 32'h1000, 0, 0, 1, 0, 0, 0);
    // ---- reset state ----
    repeat (2) @(negedge clk);
    chk("rst_iok", inst_addr_ok, 0);
    chk("rst_dok", data_addr_ok, 0);
    chk("rst_arvalid", arvalid, 0);
    chk("rst_arid", arid, 0);
    chk("rst_araddr", araddr, 0);
    chk("rst_arsize", arsize, 0);
    chk("arlen", arlen, 0);
    chk("arburst", arburst, 1);
    chk("arlock_cache_prot", {arlock, arcache, arprot}, 0);
    @(posedge clk); #1;
    resetn = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    // ---- vector table: ir dr daddr wb waddr ardy rv rid rl | iok dok av id addr size ----
    add(0,0,0,0,0,0,0,0,0,             0,0,0,0,0,0);
    add(1,0,0,0,0,0,0,0,0,             1,0,0,0,0,0);
    add(0,0,0,0,0,1,0,0,0,             0,0,1,0,IA,2);
    add(1,1,32'h1000,0,0,0,0,0,0,      0,1,0,0,IA,2);
    for (int i = 0; i < 5; i++)
      add(1,1,32'h1000,0,0,0,0,0,0,    0,0,1,1,32'h1000,1);
    add(1,1,32'h1000,0,0,1,0,0,0,      0,0,1,1,32'h1000,1);
    add(0,1,32'h1000,0,0,0,0,0,0,      0,1,0,1,32'h1000,1);
    add(0,0,32'h1000,0,0,1,0,0,0,      0,0,1,1,32'h1000,1);
    add(0,1,32'h1000,0,0,0,0,0,0,      0,0,0,1,32'h1000,1);
    add(0,1,32'h1000,0,0,0,1,1,0,      0,0,0,1,32'h1000,1);
    add(0,1,32'h1000,0,0,0,0,0,0,      0,0,0,1,32'h1000,1);
    add(0,1,32'h1000,0,0,0,1,1,1,      0,0,0,1,32'h1000,1);
    add(0,1,32'h1000,0,0,0,0,0,0,      0,1,0,1,32'h1000,1);
    add(0,0,32'h1000,0,0,1,0,0,0,      0,0,1,1,32'h1000,1);
    for (int i = 0; i < 3; i++)
      add(0,0,32'h1000,0,0,0,1,1,1,    0,0,0,1,32'h1000,1);
    add(0,1,32'h2006,1,32'h2004,0,0,0,0, 0,0,0,1,32'h1000,1);
    add(1,1,32'h2006,1,32'h2004,0,0,0,0, 1,0,0,1,32'h1000,1);
    add(0,0,0,0,0,1,0,0,0,             0,0,1,0,IA,2);
    add(0,1,32'h2008,1,32'h2004,0,0,0,0, 0,1,0,0,IA,2);
    add(0,0,0,0,0,1,0,0,0,             0,0,1,1,32'h2008,1);
    add(0,1,32'h2006,0,32'h2004,0,0,0,0, 0,1,0,1,32'h2008,1);
    add(0,0,0,0,0,1,0,0,0,             0,0,1,1,32'h2006,1);
    add(1,1,32'h2006,0,0,0,0,0,0,      0,0,0,1,32'h2006,1);
    add(1,0,0,0,0,0,1,0,1,             0,0,0,1,32'h2006,1);
    add(1,0,0,0,0,0,0,0,0,             1,0,0,1,32'h2006,1);
    add(0,0,0,0,0,1,1,0,1,             0,0,1,0,IA,2);
    add(1,0,0,0,0,0,0,0,0,             1,0,0,0,IA,2);
    add(0,0,0,0,0,1,0,0,0,             0,0,1,0,IA,2);
    add(1,0,0,0,0,0,0,0,0,             0,0,0,0,IA,2);
    foreach (tbl[i]) begin
      @(posedge clk); #1;
      drive(tbl[i].ir, tbl[i].dr, tbl[i].da, tbl[i].wb, tbl[i].wa, tbl[i].ardy, tbl[i].rv, tbl[i].rd, tbl[i].rl);
      @(negedge clk);
      chk($sformatf("v%0d_iok", i), inst_addr_ok, tbl[i].iok);
      chk($sformatf("v%0d_dok", i), data_addr_ok, tbl[i].dok);
      chk($sformatf("v%0d_arvalid", i), arvalid, tbl[i].av);
      chk($sformatf("v%0d_arid", i), arid, tbl[i].id);
      chk($sformatf("v%0d_araddr", i), araddr, tbl[i].addr);
      chk($sformatf("v%0d_arsize", i), arsize, tbl[i].sz);
    end
    // ---- reset asserted mid-ISSUE with one inst read outstanding ----
    @(posedge clk); #1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    resetn = 1'b0;
    @(posedge clk); #1;
    resetn = 1'b1;
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk); chk("rs_grant1", inst_addr_ok, 1);
    @(posedge clk); #1; drive(0, 0, 0, 0, 0, 1, 0, 0, 0);
    @(negedge clk); chk("rs_issue1", arvalid, 1);
    @(posedge clk); #1; drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk); chk("rs_grant2", inst_addr_ok, 1);
    @(posedge clk); #1;
    @(negedge clk); chk("rs_issue2", arvalid, 1);
    #2 resetn = 1'b0;
    #1;
    chk("rs_arvalid_drop", arvalid, 0);
    chk("rs_araddr_clr", araddr, 0);
    chk("rs_iok_in_rst", inst_addr_ok, 0);
    @(posedge clk); #1; resetn = 1'b1;
    @(negedge clk); chk("rs_post_grant1", inst_addr_ok, 1);
    @(posedge clk); #1; drive(0, 0, 0, 0, 0, 1, 0, 0, 0);
    @(negedge clk);
    chk("rs_post_arvalid", arvalid, 1);
    chk("rs_post_araddr", araddr, IA);
    @(posedge clk); #1; drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk); chk("rs_cnt_cleared", inst_addr_ok, 1);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
